// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing default and receiver state encoding
//
// Purpose: the UART transmitter and receiver both import this package. They
//          share the bit-period default and the 3-bit FSM state codes.
// Ports:   none (package).
package uart_pkg;

  // Bit period is UARTTIMING_DEFAULT+1 clock cycles.
  localparam int UARTTIMING_DEFAULT = 100;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and consumer-side signals of the UART receiver
//
// Purpose: groups the receiver's line input and its byte-delivery outputs.
// Signals: RX (serial line, idle high), READ (consumer acknowledge),
//          RXDATA[7:0], RXVALID, FRAMEERR, BUSY, OVERRUN.
// Modports: slave  - the receiver (drives the outputs).
//           master - the line driver / consumer (drives RX and READ).
interface uart_rx_if;
  logic       RX;
  logic       READ;
  logic [7:0] RXDATA;
  logic       RXVALID;
  logic       FRAMEERR;
  logic       BUSY;
  logic       OVERRUN;

  modport slave (
    input  RX, READ,
    output RXDATA, RXVALID, FRAMEERR, BUSY, OVERRUN
  );

  modport master (
    output RX, READ,
    input  RXDATA, RXVALID, FRAMEERR, BUSY, OVERRUN
  );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser with reset value 1
//
// Purpose: brings asynchronous inputs into the CLK domain. It resets to 1,
//          so an idle-high serial line does not look like a start edge
//          when reset is released.
// Ports:   CLK (clock), RST (async active-low reset),
//          d[WIDTH-1:0] (async input), q[WIDTH-1:0] (synchronised output).
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 asynchronous serial receiver with mid-bit sampling
//
// Purpose: oversamples RX with CLK and validates the start bit at mid-bit.
//          It then samples 8 data bits LSB-first and checks the stop bit.
//          Each good byte is delivered with a valid strobe. A bad stop bit
//          gives a framing-error pulse.
// Ports:   CLK (clock), RST (async active-low reset),
//          bus (uart_rx_if.slave: RX, READ in; RXDATA, RXVALID, FRAMEERR,
//          BUSY, OVERRUN out).
// Config:  UART_RX_OVERRUN_EN - when defined, RXVALID is a level cleared by
//          READ and OVERRUN flags an unread byte that was overwritten.
//          When undefined, RXVALID is a 1-cycle pulse and OVERRUN is 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int UARTTIMING = UARTTIMING_DEFAULT
) (
  input logic      CLK,
  input logic      RST,
  uart_rx_if.slave bus
);

  localparam int HALF = UARTTIMING / 2;
  localparam int CW   = $clog2(UARTTIMING + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_FULL = CW'(UARTTIMING);

  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    rxdata;
  logic          rxvalid;
  logic          frameerr;
`ifdef UART_RX_OVERRUN_EN
  logic          overrun;
`endif

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (bus.RX),
    .q   (rx_s)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rxdata   <= '0;
      rxvalid  <= 1'b0;
      frameerr <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
      overrun  <= 1'b0;
`endif
    end else begin
      frameerr <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
      // The consumer acknowledge clears both flags. A frame completing in
      // the same cycle overrides this below.
      if (bus.READ) begin
        rxvalid <= 1'b0;
        overrun <= 1'b0;
      end
`else
      rxvalid  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line that is high again at mid-start-bit was a glitch.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              rxdata  <= shift;
              rxvalid <= 1'b1;
`ifdef UART_RX_OVERRUN_EN
              if (rxvalid && !bus.READ) overrun <= 1'b1;
`endif
              // Returning to IDLE at mid-stop-bit leaves half a bit of
              // margin, so the next start edge can follow immediately.
              state <= IDLE;
            end else begin
              frameerr <= 1'b1;
              state    <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.RXDATA   = rxdata;
  assign bus.RXVALID  = rxvalid;
  assign bus.FRAMEERR = frameerr;
  assign bus.BUSY     = (state != IDLE);
`ifdef UART_RX_OVERRUN_EN
  assign bus.OVERRUN  = overrun;
`else
  assign bus.OVERRUN  = 1'b0;
`endif

endmodule
